// File: rtl/sseg_pkg.sv
// sseg_pkg: segment encodings, BCD limit and sizing helper shared by the
// seven-segment BCD counter and its decoder.
package sseg_pkg;

    // Segment order a,b,c,d,e,f,g,dp on bits 7..0, active-high, dp unused.
    localparam logic [7:0] SEG_0     = 8'hFC;
    localparam logic [7:0] SEG_1     = 8'h60;
    localparam logic [7:0] SEG_2     = 8'hDA;
    localparam logic [7:0] SEG_3     = 8'hF2;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'hB6;
    localparam logic [7:0] SEG_6     = 8'hBE;
    localparam logic [7:0] SEG_7     = 8'hE0;
    localparam logic [7:0] SEG_8     = 8'hFE;
    localparam logic [7:0] SEG_9     = 8'hF6;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Bits needed to hold values 0..v-1, never less than 1.
    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sseg_decode.sv
// sseg_decode: combinational BCD digit to seven-segment pattern.
//   digit in  4  BCD value 0..9
//   seg   out 8  a..g,dp on bits 7..0, active-high; non-BCD input blanks
module sseg_decode
    import sseg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] seg
);

    always_comb begin
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_counter_sseg.sv
// bcd_counter_sseg: prescaled multi-digit up/down BCD counter with a
// time-multiplexed seven-segment scan driver.
//   clk   in  1            system clock
//   rst   in  1            asynchronous reset, active-high
//   en    in  1            count enable (prescaler and count hold when low)
//   up_dn in  1            1 = up, 0 = down, sampled on count steps
//   clr   in  1            synchronous clear of count, prescaler and wrap
//   count out 4*NUM_DIGITS packed BCD, digit 0 in [3:0]
//   wrap  out 1            one-cycle pulse on 99..9->0 or 0->99..9
//   seg   out 8            a..g,dp on bits 7..0, active-high
//   an    out NUM_DIGITS   one-hot digit select, active-high
// Optional: define SSEG_LZ_BLANK_EN for leading-zero blanking.
module bcd_counter_sseg
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 16777216,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    up_dn,
    input  logic                    clr,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    wrap,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int PW = clog2(TICK_DIV);
    localparam int SW = clog2(SCAN_DIV);
    localparam int IW = clog2(NUM_DIGITS);

    logic [PW-1:0]           pre;
    logic [SW-1:0]           scan;
    logic [IW-1:0]           idx;
    logic                    tick;
    logic [4*NUM_DIGITS-1:0] nxt;
    logic [NUM_DIGITS:0]     run;
    logic [3:0]              cd;
    logic [3:0]              cur;
    logic                    blank;
    logic [7:0]              dec;

    assign tick = en && pre == PW'(TICK_DIV - 1);

    // run[i]: every digit below i sits at the roll-over value for the
    // current direction, so digit i steps; run[NUM_DIGITS] means wrap.
    always_comb begin
        run[0] = 1'b1;
        nxt = count;
        cd = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            cd = count[4*i +: 4];
            if (run[i])
                nxt[4*i +: 4] = up_dn ? ((cd == BCD_MAX) ? 4'd0 : cd + 4'd1)
                                      : ((cd == 4'd0) ? BCD_MAX : cd - 4'd1);
            run[i+1] = run[i] && cd == (up_dn ? BCD_MAX : 4'd0);
        end
    end

`ifdef SSEG_LZ_BLANK_EN
    // zh[i]: digit i and all digits above it are zero.
    logic [NUM_DIGITS:0] zh;
    always_comb begin
        zh[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--)
            zh[i] = zh[i+1] && count[4*i +: 4] == 4'd0;
    end
`endif

    always_comb begin
        cur = '0;
        blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IW'(i) == idx) begin
                cur = count[4*i +: 4];
`ifdef SSEG_LZ_BLANK_EN
                blank = (i != 0) && zh[i];
`endif
            end
        end
    end

    sseg_decode u_dec (
        .digit(cur),
        .seg  (dec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            pre   <= '0;
            wrap  <= 1'b0;
        end else if (clr) begin
            count <= '0;
            pre   <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= tick && run[NUM_DIGITS];
            if (en)
                pre <= tick ? '0 : pre + 1'b1;
            if (tick)
                count <= nxt;
        end
    end

    // Scan runs freely; an and seg are registered together so they never
    // disagree about which digit is shown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan <= '0;
            idx  <= '0;
            an   <= '0;
            seg  <= SEG_BLANK;
        end else begin
            scan <= (scan == SW'(SCAN_DIV - 1)) ? '0 : scan + 1'b1;
            if (scan == SW'(SCAN_DIV - 1))
                idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            an  <= NUM_DIGITS'(1) << idx;
            seg <= blank ? SEG_BLANK : dec;
        end
    end

endmodule

// File: tb/tb_bcd_counter_sseg.sv
// tb_bcd_counter_sseg: directed and randomized checks of bcd_counter_sseg
// against an integer-arithmetic reference model.
module tb_bcd_counter_sseg;

    localparam int ND = 2;
    localparam int TD = 4;
    localparam int SD = 3;
    localparam int M  = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          up_dn = 1'b1;
    logic          clr = 1'b0;
    logic [4*ND-1:0] count;
    logic          wrap;
    logic [7:0]    seg;
    logic [ND-1:0] an;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    int mv, mp, ms, mi, mw, man, mseg;
    int tbl [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

    bcd_counter_sseg #(.NUM_DIGITS(ND), .TICK_DIV(TD), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr),
        .count(count), .wrap(wrap), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    function automatic int to_bcd(input int v);
        int r = 0;
        for (int i = 0; i < ND; i++) r += ((v / (10 ** i)) % 10) << (4 * i);
        return r;
    endfunction

    task automatic model_reset();
        mv = 0; mp = 0; ms = 0; mi = 0; mw = 0; man = 0; mseg = 0;
    endtask

    task automatic model_edge();
        bit tick;
        bit blank;
        if (rst) begin
            model_reset();
            return;
        end
        tick = en && mp == TD - 1;
        blank = 1'b0;
`ifdef SSEG_LZ_BLANK_EN
        blank = mi > 0 && mv < 10 ** mi;
`endif
        man = 1 << mi;
        mseg = blank ? 0 : tbl[(mv / (10 ** mi)) % 10];
        if (ms == SD - 1) begin
            ms = 0;
            mi = (mi + 1) % ND;
        end else ms++;
        if (clr) begin
            mv = 0; mp = 0; mw = 0;
        end else begin
            mw = 0;
            if (en) mp = tick ? 0 : mp + 1;
            if (tick) begin
                if (up_dn) begin
                    mw = (mv == M - 1);
                    mv = (mv + 1) % M;
                end else begin
                    mw = (mv == 0);
                    mv = (mv + M - 1) % M;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(to_bcd(mv)));
        chk({tag, ".wrap"},  32'(wrap),  32'(mw));
        chk({tag, ".an"},    32'(an),    32'(man));
        chk({tag, ".seg"},   32'(seg),   32'(mseg));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk_all(tag);
    endtask

    task automatic steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    int wraps;

    initial begin
        model_reset();
        #1;
        chk_all("rst_init");
        step("rst_hold");
        rst = 1'b0;
        step("rst_release");
        chk("first_an", 32'(an), 32'h01);
        chk("first_seg", 32'(seg), 32'hFC);

        en = 1'b1; up_dn = 1'b1;
        wraps = 0;
        for (int i = 0; i < 4 * 100; i++) begin
            step("up_run");
            if (wrap) wraps++;
        end
        chk("up_wrap_count", 32'(wraps), 32'd1);
        chk("up_full_cycle", 32'(count), 32'h00);

        clr = 1'b1;
        step("clr_load");
        clr = 1'b0; up_dn = 1'b0;
        steps("down_run", 8);

        for (int i = 0; i < 10 && mp != 2; i++) step("seek_p2");
        chk("seek_p2_reached", 32'(mp), 32'd2);
        en = 1'b0;
        steps("en_low", 10);
        en = 1'b1;
        steps("en_resume", 6);

        up_dn = 1'b1;
        for (int i = 0; i < 600 && !(mv == 99 && mp == TD - 1); i++) step("seek_99");
        chk("seek_99_reached", 32'(mv), 32'd99);
        clr = 1'b1;
        step("clr_on_tick");
        chk("clr_on_tick_wrap", 32'(wrap), 32'd0);
        clr = 1'b0;
        steps("after_clr", 5);

        clr = 1'b1;
        step("clr_to7");
        clr = 1'b0;
        steps("up_to7", 7 * TD);
        en = 1'b0;
        chk("hold7", 32'(count), 32'h07);
        steps("scan7", 12);

        steps("pre_midrst", 9);
        en = 1'b1;
        steps("pre_midrst_run", 13);
        rst = 1'b1;
        model_reset();
        #1;
        chk_all("midrst_async");
        step("midrst_hold");
        rst = 1'b0;
        step("midrst_release");

        for (int i = 0; i < 400; i++) begin
            en    = ($urandom_range(0, 9) != 0);
            up_dn = $urandom_range(0, 1) == 1;
            clr   = ($urandom_range(0, 39) == 0);
            step("random");
        end
        clr = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
